// File: rtl/mc51_prefetch_unit.sv
// mc51 instruction prefetch: runs program-memory reads ahead into a byte queue.
// Optional bus watchdog enabled with `define FETCH_WDT_EN.
module mc51_prefetch_unit #(
    parameter int unsigned   AW         = 16,
    parameter int unsigned   DEPTH      = 4,
    parameter logic [AW-1:0] RESET_PC   = '0,
    parameter int unsigned   WDT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_jmp,
    input  logic [AW-1:0]              i_jmp_addr,
    input  logic                       i_instr_take,
    output logic                       o_instr_valid,
    output logic [7:0]                 o_instr,
    output logic [AW-1:0]              o_instr_pc,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [AW-1:0]              o_mem_addr,
    output logic                       o_psen_n,
    output logic                       o_rd_n,
    input  logic [7:0]                 i_mem_rdata,
    input  logic                       i_data_rdy,
    output logic                       o_bus_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    if (DEPTH < 2 || WDT_CYCLES < 2) begin : g_param_chk
        $error("mc51_prefetch_unit: DEPTH and WDT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [7:0]    q_data [DEPTH];
    logic [AW-1:0] q_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] level;
    logic [AW-1:0] fetch_addr;
    logic          discard;

    logic          start;
    logic          done;
    logic          push;
    logic          pop;
    logic          timeout;

    assign start = (state_q == IDLE) && !i_jmp && (level < LW'(DEPTH));
    assign done  = (state_q == BUS) && (i_data_rdy || timeout);
    assign push  = (state_q == BUS) && i_data_rdy && !discard && !i_jmp;
    assign pop   = o_instr_valid && i_instr_take && !i_jmp;

    assign o_instr_valid = (level != '0);
    assign o_level       = level;
    assign o_instr       = q_data[rd_ptr];
    assign o_instr_pc    = q_pc[rd_ptr];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = BUS;
            BUS:     if (done) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            o_mem_addr <= RESET_PC;
            o_psen_n   <= 1'b1;
            o_rd_n     <= 1'b1;
            fetch_addr <= RESET_PC;
            discard    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                o_mem_addr <= fetch_addr;
                o_psen_n   <= 1'b0;
                o_rd_n     <= 1'b0;
            end else if (done) begin
                o_psen_n <= 1'b1;
                o_rd_n   <= 1'b1;
            end
            if (i_jmp) begin
                fetch_addr <= i_jmp_addr;
            end else if (push) begin
                fetch_addr <= fetch_addr + 1'b1;
            end
            // A redirect that lands mid-access poisons the byte still in flight
            if (state_q == BUS && i_jmp && !done) begin
                discard <= 1'b1;
            end else if (state_q == BUS && i_data_rdy) begin
                discard <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= 8'h00;
                q_pc[i]   <= RESET_PC;
            end
        end else if (i_jmp) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= i_mem_rdata;
                q_pc[wr_ptr]   <= fetch_addr;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef FETCH_WDT_EN
    localparam int unsigned CW = $clog2(WDT_CYCLES + 1);

    logic [CW-1:0] wdt_cnt;
    logic          bus_err_q;

    assign timeout   = (state_q == BUS) && !i_data_rdy &&
                       (wdt_cnt == CW'(WDT_CYCLES - 1));
    assign o_bus_err = bus_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_cnt   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            if (start) begin
                wdt_cnt <= '0;
            end else if (state_q == BUS && !i_data_rdy) begin
                wdt_cnt <= wdt_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign o_bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mc51_prefetch_unit.sv
// Directed bench for mc51_prefetch_unit: table-driven fill/pop sequence
// plus hand-written redirect, wrap, watchdog and reset corner cases.
module tb_mc51_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_jmp;
    logic [15:0] i_jmp_addr;
    logic        i_instr_take;
    logic        o_instr_valid;
    logic [7:0]  o_instr;
    logic [15:0] o_instr_pc;
    logic [2:0]  o_level;
    logic [15:0] o_mem_addr;
    logic        o_psen_n;
    logic        o_rd_n;
    logic [7:0]  i_mem_rdata;
    logic        i_data_rdy;
    logic        o_bus_err;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_delay = 0;
    int wait_cnt = 0;
    logic prev_psen = 1'b1;
    logic [15:0] acc_log[$];

    mc51_prefetch_unit #(
        .AW(16),
        .DEPTH(4),
        .RESET_PC(16'h0100),
        .WDT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_jmp(i_jmp),
        .i_jmp_addr(i_jmp_addr),
        .i_instr_take(i_instr_take),
        .o_instr_valid(o_instr_valid),
        .o_instr(o_instr),
        .o_instr_pc(o_instr_pc),
        .o_level(o_level),
        .o_mem_addr(o_mem_addr),
        .o_psen_n(o_psen_n),
        .o_rd_n(o_rd_n),
        .i_mem_rdata(i_mem_rdata),
        .i_data_rdy(i_data_rdy),
        .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_level(input int lvl);
        for (int i = 0; i < 200 && int'(o_level) != lvl; i++) @(negedge clk);
    endtask

    task automatic wait_psen(input logic v);
        for (int i = 0; i < 200 && o_psen_n !== v; i++) @(negedge clk);
    endtask

    task automatic pulse_take();
        i_instr_take = 1'b1;
        @(negedge clk);
        i_instr_take = 1'b0;
    endtask

    task automatic pulse_jmp(input logic [15:0] a, input logic take);
        i_jmp = 1'b1;
        i_jmp_addr = a;
        i_instr_take = take;
        @(negedge clk);
        i_jmp = 1'b0;
        i_instr_take = 1'b0;
    endtask

    // Program-memory model: logs each access, answers after rdy_delay waits
    initial begin
        i_data_rdy = 1'b0;
        i_mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!o_psen_n) begin
                if (prev_psen) begin
                    wait_cnt = 0;
                    acc_log.push_back(o_mem_addr);
                end else begin
                    wait_cnt++;
                end
                i_data_rdy = (wait_cnt >= rdy_delay);
                i_mem_rdata = mem_byte(o_mem_addr);
            end else begin
                i_data_rdy = 1'b0;
                i_mem_rdata = 8'h00;
            end
            prev_psen = o_psen_n;
        end
    end

    typedef struct {
        logic        take;
        logic        psen;
        int          level;
        logic [15:0] pc;
        logic [15:0] addr;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int n0;
        int n;
        vecs[0]  = '{1'b0, 1'b0, 0, 16'h0100, 16'h0100};
        vecs[1]  = '{1'b0, 1'b1, 1, 16'h0100, 16'h0100};
        vecs[2]  = '{1'b0, 1'b1, 1, 16'h0100, 16'h0100};
        vecs[3]  = '{1'b0, 1'b0, 1, 16'h0100, 16'h0101};
        vecs[4]  = '{1'b0, 1'b1, 2, 16'h0100, 16'h0101};
        vecs[5]  = '{1'b0, 1'b1, 2, 16'h0100, 16'h0101};
        vecs[6]  = '{1'b0, 1'b0, 2, 16'h0100, 16'h0102};
        vecs[7]  = '{1'b0, 1'b1, 3, 16'h0100, 16'h0102};
        vecs[8]  = '{1'b0, 1'b1, 3, 16'h0100, 16'h0102};
        vecs[9]  = '{1'b0, 1'b0, 3, 16'h0100, 16'h0103};
        vecs[10] = '{1'b0, 1'b1, 4, 16'h0100, 16'h0103};
        vecs[11] = '{1'b0, 1'b1, 4, 16'h0100, 16'h0103};
        vecs[12] = '{1'b0, 1'b1, 4, 16'h0100, 16'h0103};
        vecs[13] = '{1'b0, 1'b1, 4, 16'h0100, 16'h0103};
        vecs[14] = '{1'b1, 1'b1, 3, 16'h0101, 16'h0103};
        vecs[15] = '{1'b0, 1'b0, 3, 16'h0101, 16'h0104};
        vecs[16] = '{1'b0, 1'b1, 4, 16'h0101, 16'h0104};
        vecs[17] = '{1'b0, 1'b1, 4, 16'h0101, 16'h0104};
        vecs[18] = '{1'b0, 1'b1, 4, 16'h0101, 16'h0104};

        reset_n = 1'b0;
        i_jmp = 1'b0;
        i_jmp_addr = 16'h0000;
        i_instr_take = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", o_instr_valid, 0);
        chk("rst_level", o_level, 0);
        chk("rst_instr", o_instr, 0);
        chk("rst_pc", o_instr_pc, 16'h0100);
        chk("rst_psen", o_psen_n, 1);
        chk("rst_rd", o_rd_n, 1);
        chk("rst_addr", o_mem_addr, 16'h0100);
        chk("rst_err", o_bus_err, 0);
        reset_n = 1'b1;

        // Fill from RESET_PC with immediate rdy, then one pop refetches
        for (int k = 0; k < 19; k++) begin
            i_instr_take = vecs[k].take;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_psen", k), o_psen_n, vecs[k].psen);
            chk($sformatf("v%0d_rd", k), o_rd_n, vecs[k].psen);
            chk($sformatf("v%0d_level", k), o_level, vecs[k].level);
            chk($sformatf("v%0d_valid", k), o_instr_valid, vecs[k].level != 0);
            chk($sformatf("v%0d_pc", k), o_instr_pc, vecs[k].pc);
            chk($sformatf("v%0d_addr", k), o_mem_addr, vecs[k].addr);
            if (vecs[k].level != 0)
                chk($sformatf("v%0d_instr", k), o_instr, mem_byte(vecs[k].pc));
        end
        i_instr_take = 1'b0;
        chk("fill_acc_count", acc_log.size(), 5);

        // Redirect while the bus is stalled waiting for rdy
        rdy_delay = 100;
        pulse_take();
        wait_psen(1'b0);
        repeat (5) @(negedge clk);
        chk("stall_psen", o_psen_n, 0);
        chk("stall_addr", o_mem_addr, 16'h0105);
        n0 = acc_log.size();
        pulse_jmp(16'h2000, 1'b0);
        chk("jmp_level", o_level, 0);
        chk("jmp_valid", o_instr_valid, 0);
        chk("jmp_bus_held", o_psen_n, 0);
        rdy_delay = 0;
        wait_level(1);
        chk("jmp_head_pc", o_instr_pc, 16'h2000);
        chk("jmp_head_instr", o_instr, mem_byte(16'h2000));
        chk("jmp_acc_count", acc_log.size(), n0 + 1);
        chk("jmp_acc_addr", acc_log[n0], 16'h2000);

        // Take and redirect together with two bytes queued
        wait_level(2);
        chk("tj_pre_level", o_level, 2);
        pulse_jmp(16'h3000, 1'b1);
        chk("tj_level", o_level, 0);
        chk("tj_valid", o_instr_valid, 0);
        n0 = acc_log.size();
        wait_level(1);
        chk("tj_level1", o_level, 1);
        chk("tj_head_pc", o_instr_pc, 16'h3000);
        chk("tj_acc_addr", acc_log[n0], 16'h3000);

        // Fetch address wraps 0xFFFF -> 0x0000
        pulse_jmp(16'hFFFF, 1'b0);
        wait_level(2);
        chk("wrap_level", o_level, 2);
        chk("wrap_head_pc", o_instr_pc, 16'hFFFF);
        chk("wrap_head_instr", o_instr, mem_byte(16'hFFFF));
        chk("wrap_acc_prev", acc_log[acc_log.size() - 2], 16'hFFFF);
        chk("wrap_acc_last", acc_log[acc_log.size() - 1], 16'h0000);
        pulse_take();
        chk("wrap_pop_level", o_level, 1);
        chk("wrap_pop_pc", o_instr_pc, 16'h0000);
        chk("wrap_pop_instr", o_instr, mem_byte(16'h0000));

        rdy_delay = 1000;
        pulse_jmp(16'h4000, 1'b0);
        wait_psen(1'b0);
        chk("wd_first_addr", o_mem_addr, 16'h4000);
`ifdef FETCH_WDT_EN
        n = 0;
        while (!o_psen_n && n < 50) begin
            chk("wd_no_err_early", o_bus_err, 0);
            n++;
            @(negedge clk);
        end
        chk("wd_bus_cycles", n, 8);
        chk("wd_err_pulse", o_bus_err, 1);
        chk("wd_psen_gap", o_psen_n, 1);
        chk("wd_level", o_level, 0);
        @(negedge clk);
        chk("wd_err_clear", o_bus_err, 0);
        chk("wd_psen_idle", o_psen_n, 1);
        @(negedge clk);
        chk("wd_retry_psen", o_psen_n, 0);
        chk("wd_retry_addr", o_mem_addr, 16'h4000);
        @(negedge clk);
        chk("wd_retry_log", acc_log[acc_log.size() - 1], 16'h4000);
        chk("wd_retry_log2", acc_log[acc_log.size() - 2], 16'h4000);
`else
        n = 0;
        repeat (20) begin
            if (!o_psen_n && !o_bus_err) n++;
            @(negedge clk);
        end
        chk("nowd_wait_cycles", n, 20);
        chk("nowd_psen", o_psen_n, 0);
        chk("nowd_err", o_bus_err, 0);
`endif
        rdy_delay = 0;
        wait_level(1);
        chk("wd_head_pc", o_instr_pc, 16'h4000);

        // Asynchronous reset in the middle of a stalled access
        rdy_delay = 1000;
        wait_psen(1'b0);
        chk("ar_pre_psen", o_psen_n, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_psen", o_psen_n, 1);
        chk("ar_rd", o_rd_n, 1);
        chk("ar_level", o_level, 0);
        chk("ar_valid", o_instr_valid, 0);
        chk("ar_addr", o_mem_addr, 16'h0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
